// File: rtl/reset_seq_ctrl.sv
// reset_seq_ctrl
//   Reset release sequencer for several downstream reset domains that share
//   one clock. The board reset is synchronised on deassertion. Once the clock
//   reports lock, the active-low domain resets are released one at a time,
//   bit 0 first, one release every DLY cycles. Loss of lock or a soft-reset
//   request pulls every domain back into reset. All domains are then held for
//   at least HOLD cycles before the sequence runs again.
//
// Ports
//   clk_A         in   system clock shared by all domains
//   nrst_in       in   board reset, asynchronous assert, active-low
//   lock_in       in   clock-lock status (1 = locked), synchronous to clk_A
//   soft_rst_req  in   soft reset request, level-sampled on every edge
//   nrst_out      out  per-domain active-low resets; bit 0 is released first
//   seq_done      out  1 once every domain has been released
//   stage_idx     out  index of the next domain to be released
module reset_seq_ctrl #(
    parameter  int N_STG = 3,   // number of sequenced domains (>= 1)
    parameter  int DLY   = 16,  // cycles between consecutive releases (>= 1)
    parameter  int HOLD  = 8,   // minimum hold time after a re-trigger (>= 1)
    parameter  int CNT_W = 8,   // 2**CNT_W must exceed max(DLY, HOLD)
    localparam int IDX_W = (N_STG > 1) ? $clog2(N_STG) : 1
) (
    input  logic             clk_A,
    input  logic             nrst_in,
    input  logic             lock_in,
    input  logic             soft_rst_req,
    output logic [N_STG-1:0] nrst_out,
    output logic             seq_done,
    output logic [IDX_W-1:0] stage_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DLY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STG - 1);

    logic [1:0]       sync_q,      sync_d;
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [IDX_W-1:0] stage_idx_q, stage_idx_d;
    logic [N_STG-1:0] nrst_out_q,  nrst_out_d;
    logic             seq_done_q,  seq_done_d;

    logic rst_sync;
    logic retrig;

    // The second sync flop is the clean, clock-aligned view of nrst_in.
    assign rst_sync = sync_q[1];
    // A soft request and a lock loss arriving together count as one re-trigger.
    assign retrig   = soft_rst_req | ~lock_in;

    always_comb begin
        // NOTE: every signal assigned here gets a default first. If a branch
        // left one unassigned, synthesis would infer a latch to hold it.
        sync_d      = {sync_q[0], 1'b1};
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_idx_d = stage_idx_q;
        nrst_out_d  = nrst_out_q;
        seq_done_d  = seq_done_q;

        unique case (state_q)
            S_IDLE: begin
                if (rst_sync && lock_in) begin
                    state_d     = S_COUNT;
                    cnt_d       = '0;
                    stage_idx_d = '0;
                end
            end

            S_COUNT: begin
                if (retrig) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    stage_idx_d = '0;
                    nrst_out_d  = '0;
                    seq_done_d  = 1'b0;
                end else if (cnt_q == DLY_LAST) begin
                    // Only the bit selected by stage_idx is set. stage_idx
                    // only moves forward, so a higher bit can never be
                    // released ahead of a lower one.
                    cnt_d = '0;
                    for (int k = 0; k < N_STG; k++) begin
                        if (stage_idx_q == IDX_W'(k)) begin
                            nrst_out_d[k] = 1'b1;
                        end
                    end
                    if (stage_idx_q == IDX_LAST) begin
                        state_d    = S_DONE;
                        seq_done_d = 1'b1;
                    end else begin
                        stage_idx_d = stage_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                if (retrig) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    stage_idx_d = '0;
                    nrst_out_d  = '0;
                    seq_done_d  = 1'b0;
                end
            end

            S_HOLD: begin
                // Each further request restarts the hold window, so domains
                // stay in reset until HOLD quiet cycles have passed.
                if (retrig) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: registers use non-blocking assignments. Every flop then samples
    // its input from before the edge, whatever order the statements are in.
    always_ff @(posedge clk_A or negedge nrst_in) begin
        if (!nrst_in) begin
            sync_q      <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stage_idx_q <= '0;
            nrst_out_q  <= '0;
            seq_done_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_idx_q <= stage_idx_d;
            nrst_out_q  <= nrst_out_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign nrst_out  = nrst_out_q;
    assign seq_done  = seq_done_q;
    assign stage_idx = stage_idx_q;

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
- Reset release sequencer for multiple downstream reset domains sharing one clock.
- Synchronizes deassertion of the board reset, waits for clock lock, then releases N active-low domain resets in a fixed order, one every DLY cycles.
- Re-asserts all domain resets and re-runs the sequence on loss of lock or on a soft-reset request.

Parameters:
- N_STG, 3, number of sequenced reset domains (>=1)
- DLY, 16, cycles between consecutive releases (>=1)
- HOLD, 8, cycles all domains are held in reset after a re-trigger (>=1)
- CNT_W, 8, counter width; must satisfy 2^CNT_W > max(DLY, HOLD)

Ports:
- clk_A  in  1  single system clock
- nrst_in  in  1  reset, asynchronous, active-low
- lock_in  in  1  clock-lock status, synchronous to clk_A, 1 = locked
- soft_rst_req  in  1  soft reset request, synchronous, level-sampled each edge
- nrst_out  out  N_STG  per-domain reset, active-low; bit 0 is released first
- seq_done  out  1  1 = all domains released
- stage_idx  out  max(1,$clog2(N_STG))  index of the next domain to release

Behaviour:
- nrst_in low, asynchronous with no clock edge needed:
  - nrst_out=0, seq_done=0, stage_idx=0, cnt=0, state=IDLE.
  - 2-flop sync chain cleared.
- Sync chain:
  - Shifts in 1 on each edge while nrst_in is high.
  - rst_sync=1 after the 2nd edge following nrst_in rising.
- States are IDLE, COUNT, DONE and HOLD.
- IDLE:
  - When rst_sync & lock_in at an edge: go to COUNT, cnt=0, stage_idx=0. Call this edge E0.
  - Otherwise stay in IDLE.
- COUNT:
  - cnt increments each edge.
  - At an edge where cnt==DLY-1: set nrst_out[stage_idx]=1 and clear cnt.
    - If stage_idx==N_STG-1: go to DONE and set seq_done=1 on the same edge.
    - Otherwise stage_idx++.
  - Result: nrst_out[k] rises at edge E0+(k+1)*DLY.
- Released bits stay 1 until a re-trigger or nrst_in.
- DONE: outputs are stable; stage_idx = N_STG-1.
- Re-trigger, applies in COUNT or DONE:
  - Condition: soft_rst_req=1 or lock_in=0 sampled at an edge.
  - That edge: nrst_out=0, seq_done=0, stage_idx=0, cnt=0, go to HOLD. Call this edge H0.
- HOLD:
  - cnt increments each edge.
  - At an edge where cnt==HOLD-1: go to IDLE.
  - soft_rst_req=1 or lock_in=0 in HOLD clears cnt, which extends the hold.
  - IDLE then re-enters COUNT on the next edge, so with lock_in high nrst_out[0] rises at H0+HOLD+1+DLY.
- Simultaneous soft_rst_req and lock loss: treated identically as one re-trigger.
- The counter never wraps, because cnt is cleared at its terminal value.
- nrst_out bits are registered outputs and glitch-free. No bit is ever released out of order.
- nrst_in assertion mid-sequence overrides everything. After it: full resync, 2 edges, then a fresh sequence.

Test Plan (N_STG=3, DLY=4, HOLD=2, edges counted after nrst_in rises):
- Power-on, lock_in=1 throughout -> rst_sync at edge 2, E0=3, nrst_out = 001 at edge 7, 011 at 11, 111 with seq_done=1 at 15.
- lock_in=0 until just before edge 10 -> E0=10, nrst_out[0] rises at 14, seq_done at 22.
- soft_rst_req=1 for one cycle at edge 20 while in DONE -> nrst_out=000 and seq_done=0 after edge 20, IDLE at 22, COUNT at 23, nrst_out[0] at 27.
- lock_in drops at edge 9, after bit 0 is released -> nrst_out=000 at edge 9; never any state where bit1=1 while bit0=0.
- soft_rst_req held high for 5 cycles in HOLD -> IDLE reached 2 edges after the last high sample; sequence then restarts normally.
- nrst_in pulled low between edges mid-COUNT -> nrst_out=000, seq_done=0 immediately, with no clock edge; on release, the sequence restarts from edge 1 timing.
